// File: rtl/resp_capture_checker_if.sv
// Handshake bundle between a stimulus/response source and resp_capture_checker.
//   start         : begin/restart a check run
//   vld           : vec/y valid this cycle
//   vec           : input vector currently applied to the DUT
//   y             : DUT response to vec
//   busy          : run in progress
//   done          : run complete, results stable
//   pass          : run complete with zero mismatches
//   err_cnt       : saturating mismatch count
//   first_err_vld : first_err_vec holds a valid failing vector
//   first_err_vec : first mismatching vector of the run
//   cov           : bit i set once vector i has been checked
// master = stimulus side, slave = checker side.
interface resp_capture_checker_if #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned CNT_W = 8
);
    logic                 start;
    logic                 vld;
    logic [N_IN-1:0]      vec;
    logic                 y;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [CNT_W-1:0]     err_cnt;
    logic                 first_err_vld;
    logic [N_IN-1:0]      first_err_vec;
    logic [2**N_IN-1:0]   cov;

    modport master (
        output start, vld, vec, y,
        input  busy, done, pass, err_cnt, first_err_vld, first_err_vec, cov
    );

    modport slave (
        input  start, vld, vec, y,
        output busy, done, pass, err_cnt, first_err_vld, first_err_vec, cov
    );
endinterface

// File: rtl/resp_capture_checker.sv
// Response-side checker for exhaustive tests of a combinational block. Each valid
// (vec, y) sample is compared against EXP_TT[vec]; the block accumulates a saturating
// mismatch count, the first failing vector and vector coverage, and reports pass/fail
// once every vector in the 2**N_IN space has been seen.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : resp_capture_checker_if slave modport (stimulus in, results out)
module resp_capture_checker #(
    parameter int unsigned        N_IN   = 3,
    parameter logic [2**N_IN-1:0] EXP_TT = 8'hE8,
    parameter int unsigned        CNT_W  = 8
) (
    input logic                   clk,
    input logic                   rst,
    resp_capture_checker_if.slave bus
);
    localparam int unsigned      NVEC    = 2**N_IN;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [CNT_W-1:0]  err_cnt_q;
    logic              first_err_vld_q;
    logic [N_IN-1:0]   first_err_vec_q;
    logic [NVEC-1:0]   cov_q;

    // Values the current sample would produce; only committed in StRun with vld.
    logic              mismatch;
    logic [NVEC-1:0]   cov_nxt;
    logic [CNT_W-1:0]  err_nxt;

    always_comb begin
        mismatch          = bus.y ^ EXP_TT[bus.vec];
        cov_nxt           = cov_q;
        cov_nxt[bus.vec]  = 1'b1;
        err_nxt           = err_cnt_q;
        if (mismatch && (err_cnt_q != CNT_MAX)) begin
            err_nxt = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_vec_q <= '0;
            cov_q           <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Results hold in StDone until a restart clears them.
                    if (bus.start) begin
                        state_q         <= StRun;
                        busy_q          <= 1'b1;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                        err_cnt_q       <= '0;
                        first_err_vld_q <= 1'b0;
                        first_err_vec_q <= '0;
                        cov_q           <= '0;
                    end
                end
                StRun: begin
                    if (bus.vld) begin
                        cov_q     <= cov_nxt;
                        err_cnt_q <= err_nxt;
                        if (mismatch && !first_err_vld_q) begin
                            first_err_vld_q <= 1'b1;
                            first_err_vec_q <= bus.vec;
                        end
                        // The sample that completes coverage also ends the run, so its
                        // own mismatch is already folded into err_nxt.
                        if (&cov_nxt) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_nxt == '0);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.first_err_vld = first_err_vld_q;
    assign bus.first_err_vec = first_err_vec_q;
    assign bus.cov           = cov_q;
endmodule

// File: tb/tb_resp_capture_checker.sv
// Bench for resp_capture_checker: two instances (CNT_W=8 and CNT_W=2) see the same
// stimulus; a behavioural model tracks the expected results per clock.
module tb_resp_capture_checker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    resp_capture_checker_if #(.N_IN(3), .CNT_W(8)) bus_a ();
    resp_capture_checker_if #(.N_IN(3), .CNT_W(2)) bus_b ();

    resp_capture_checker #(.N_IN(3), .EXP_TT(8'hE8), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    resp_capture_checker #(.N_IN(3), .EXP_TT(8'hE8), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit       m_busy;
    bit       m_done;
    int       m_raw;      // unbounded mismatch count
    bit       m_fv;
    int       m_fvec;
    bit       m_seen[8];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit maj(input int v);
        return $countones(v[2:0]) >= 2;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit v, input int vv, input bit yy);
        int covered;
        if (r) begin
            m_busy = 0; m_done = 0; m_raw = 0; m_fv = 0; m_fvec = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end else if (!m_busy && s) begin
            m_busy = 1; m_done = 0; m_raw = 0; m_fv = 0; m_fvec = 0;
            foreach (m_seen[i]) m_seen[i] = 0;
        end else if (m_busy && v) begin
            if (yy != maj(vv)) begin
                m_raw++;
                if (!m_fv) begin m_fv = 1; m_fvec = vv; end
            end
            m_seen[vv] = 1;
            covered = 0;
            foreach (m_seen[i]) covered += m_seen[i];
            if (covered == 8) begin m_busy = 0; m_done = 1; end
        end
    endtask

    task automatic compare_all();
        int exp_cov;
        int sat_a;
        int sat_b;
        bit exp_pass;
        exp_cov = 0;
        foreach (m_seen[i]) if (m_seen[i]) exp_cov |= (1 << i);
        sat_a = (m_raw > 255) ? 255 : m_raw;
        sat_b = (m_raw > 3) ? 3 : m_raw;
        exp_pass = m_done && (m_raw == 0);
        check_eq("a.busy", bus_a.busy, m_busy);
        check_eq("a.done", bus_a.done, m_done);
        check_eq("a.pass", bus_a.pass, exp_pass);
        check_eq("a.err_cnt", bus_a.err_cnt, sat_a);
        check_eq("a.first_err_vld", bus_a.first_err_vld, m_fv);
        check_eq("a.first_err_vec", bus_a.first_err_vec, m_fvec);
        check_eq("a.cov", bus_a.cov, exp_cov);
        check_eq("b.busy", bus_b.busy, m_busy);
        check_eq("b.done", bus_b.done, m_done);
        check_eq("b.pass", bus_b.pass, exp_pass);
        check_eq("b.err_cnt", bus_b.err_cnt, sat_b);
        check_eq("b.first_err_vld", bus_b.first_err_vld, m_fv);
        check_eq("b.first_err_vec", bus_b.first_err_vec, m_fvec);
        check_eq("b.cov", bus_b.cov, exp_cov);
    endtask

    // One clock: drive inputs, advance model on the edge, compare just after it.
    // With v=0, vec/y get random junk that must be ignored.
    task automatic cyc(input bit r, input bit s, input bit v, input int vv, input bit flip);
        logic [2:0] vec3;
        logic       yy;
        if (v) begin
            vec3 = 3'(vv);
            yy   = maj(vv) ^ flip;
        end else begin
            vec3 = 3'($urandom_range(0, 7));
            yy   = 1'($urandom_range(0, 1));
        end
        rst = r;
        bus_a.start = s; bus_a.vld = v; bus_a.vec = vec3; bus_a.y = yy;
        bus_b.start = s; bus_b.vld = v; bus_b.vec = vec3; bus_b.y = yy;
        @(posedge clk);
        model_step(r, s, v, int'(vec3), yy);
        #1;
        compare_all();
    endtask

    // Start a run, then apply order[]; entry -1 means a vld=0 gap cycle.
    // bad[k]=1 inverts y for order[k].
    task automatic run_seq(input int order[$], input bit bad[$]);
        cyc(0, 1, 0, 0, 0);
        for (int k = 0; k < order.size(); k++) begin
            if (order[k] < 0) cyc(0, 0, 0, 0, 0);
            else cyc(0, 0, 1, order[k], bad[k]);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 1);  // vld in DONE is ignored
    endtask

    initial begin
        rst = 1'b1;
        bus_a.start = 0; bus_a.vld = 0; bus_a.vec = '0; bus_a.y = 0;
        bus_b.start = 0; bus_b.vld = 0; bus_b.vec = '0; bus_b.y = 0;

        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 2, 1);

        // Reset mid-run, then vld without start does nothing
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 1, 2, 0);
        cyc(0, 0, 1, 3, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 4, 1);
        cyc(0, 0, 1, 5, 0);

        // Golden run
        run_seq('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 0, 0, 0, 0, 0, 0});
        // Faulty DUT on vec 3 and 6
        run_seq('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 0, 1, 0, 0, 1, 0});
        // Out of order, repeats, gaps
        run_seq('{5, 5, 2, -1, -1, -1, 7, 0, 1, 3, 4, 6},
                '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        // Everything inverted: instance b saturates at 3
        run_seq('{0, 1, 2, 3, 4, 5, 6, 7}, '{1, 1, 1, 1, 1, 1, 1, 1});

        // Start mid-run is ignored; end with two errors, then restart into a golden run
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 1, 1, 2, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 3, 0);
        cyc(0, 0, 1, 4, 1);
        cyc(0, 0, 1, 5, 0);
        cyc(0, 0, 1, 6, 1);
        cyc(0, 0, 1, 7, 0);
        cyc(0, 0, 0, 0, 0);
        run_seq('{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 0, 0, 0, 0, 0, 0, 0});

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 7) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
